// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: op codes,
// sequencer states and unit-select encoding.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    localparam logic UNIT_MULT = 1'b0;
    localparam logic UNIT_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_WAIT   = 2'b10
    } state_e;

    function automatic logic unit_of(input logic [1:0] op);
        return (op == OP_DIV) ? UNIT_DIV : UNIT_MULT;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/unit/result bundle between control unit, sequencer and
// the multiply/divide datapath.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_ready;
    logic             busy;
    logic             unit_start;
    logic             unit_sel;
    logic [WIDTH-1:0] unit_a;
    logic [WIDTH-1:0] unit_b;
    logic             unit_done;
    logic [WIDTH-1:0] unit_hi;
    logic [WIDTH-1:0] unit_lo;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_zero_exc;
    logic             timeout_err;

    modport master (
        output op_valid, op_code, op_a, op_b,
        output unit_done, unit_hi, unit_lo,
        input  op_ready, busy, unit_start, unit_sel,
        input  unit_a, unit_b, hi_out, lo_out,
        input  div_zero_exc, timeout_err
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b,
        input  unit_done, unit_hi, unit_lo,
        output op_ready, busy, unit_start, unit_sel,
        output unit_a, unit_b, hi_out, lo_out,
        output div_zero_exc, timeout_err
    );
endinterface

// File: rtl/muldiv_ctrl_hilo_regs.sv
// Architectural HI/LO pair: independent MTHI/MTLO writes plus a joint
// result write from the multiply/divide units.
module hilo_regs #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hi_we_i,
    input  logic [WIDTH-1:0] hi_wd_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] lo_wd_i,
    input  logic             res_we_i,
    input  logic [WIDTH-1:0] res_hi_i,
    input  logic [WIDTH-1:0] res_lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (res_we_i) begin
            hi_d = res_hi_i;
            lo_d = res_lo_i;
        end else begin
            if (hi_we_i) hi_d = hi_wd_i;
            if (lo_we_i) lo_d = lo_wd_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: accepts requests, launches a unit, owns HI/LO.
// Optional WAIT-state watchdog enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic    clk,
    input  logic    Reset,
    muldiv_if.slave bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sel_q, sel_d;
    logic             dz_q, dz_d;
    logic             hi_we, lo_we, res_we;
    logic             b_zero;
    logic             is_mthi, is_mtlo, is_dz;

`ifdef MULDIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
`endif

    assign b_zero  = (bus.op_b == '0);
    assign is_mthi = (bus.op_code == OP_MTHI);
    assign is_mtlo = (bus.op_code == OP_MTLO);
    assign is_dz   = (bus.op_code == OP_DIV) && b_zero;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        dz_d    = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        res_we  = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    unique case (1'b1)
                        is_mthi: hi_we = 1'b1;
                        is_mtlo: lo_we = 1'b1;
                        is_dz:   dz_d  = 1'b1;
                        default: begin
                            a_d     = bus.op_a;
                            b_d     = bus.op_b;
                            sel_d   = unit_of(bus.op_code);
                            state_d = ST_LAUNCH;
                        end
                    endcase
                end
            end
            ST_LAUNCH: begin
                // a done pulse here belongs to nothing we launched
                state_d = ST_WAIT;
`ifdef MULDIV_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (bus.unit_done) begin
                    res_we  = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef MULDIV_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    to_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= UNIT_MULT;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            dz_q    <= dz_d;
        end
    end

`ifdef MULDIV_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
    assign bus.timeout_err = to_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    hilo_regs #(
        .WIDTH(WIDTH)
    ) u_hilo (
        .clk_i   (clk),
        .rst_i   (Reset),
        .hi_we_i (hi_we),
        .hi_wd_i (bus.op_a),
        .lo_we_i (lo_we),
        .lo_wd_i (bus.op_a),
        .res_we_i(res_we),
        .res_hi_i(bus.unit_hi),
        .res_lo_i(bus.unit_lo),
        .hi_o    (bus.hi_out),
        .lo_o    (bus.lo_out)
    );

    assign bus.op_ready     = (state_q == ST_IDLE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.unit_start   = (state_q == ST_LAUNCH);
    assign bus.unit_sel     = sel_q;
    assign bus.unit_a       = a_q;
    assign bus.unit_b       = b_q;
    assign bus.div_zero_exc = dz_q;

endmodule
